// File: rtl/mfp_pmod_als_spi_sampler_pkg.sv
// rtl/mfp_pmod_als_spi_sampler_pkg.sv - shared state encoding and default parameters
// Purpose: FSM state type and default parameter values for the PmodALS SPI sampler.
// Ports: none (package).
package mfp_pmod_als_spi_sampler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  localparam int unsigned DEF_CLK_DIV       = 8;
  localparam int unsigned DEF_SAMPLE_PERIOD = 100000;
  localparam int unsigned DEF_FRAME_BITS    = 16;
  localparam int unsigned DEF_DATA_MSB      = 12;
  localparam int unsigned DEF_DATA_LSB      = 5;

endpackage

// File: rtl/mfp_sync2.sv
// rtl/mfp_sync2.sv - two-flop synchronizer, resets to 1
// Purpose: bring an asynchronous single-bit input into the clock domain.
// Ports: clock, reset (async, active-high), d (async input), q (synchronized output).
module mfp_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/mfp_pmod_als_spi_sampler.sv
// rtl/mfp_pmod_als_spi_sampler.sv - SPI master sampler for the PmodALS light sensor
// Purpose: generates cs/sck, shifts in sdo, publishes the last complete frame and
//   the extracted light value; conversions are free-running or start-triggered.
// Ports: clock, reset (async, active-high); enable (free-run), start (one-shot pulse);
//   cs, sck, sdo (SPI); frame, value, valid (result); busy (conversion in progress).
module mfp_pmod_als_spi_sampler
  import mfp_pmod_als_spi_sampler_pkg::*;
#(
  parameter int unsigned CLK_DIV       = DEF_CLK_DIV,
  parameter int unsigned SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int unsigned FRAME_BITS    = DEF_FRAME_BITS,
  parameter int unsigned DATA_MSB      = DEF_DATA_MSB,
  parameter int unsigned DATA_LSB      = DEF_DATA_LSB
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         start,
  output logic                         cs,
  output logic                         sck,
  input  logic                         sdo,
  output logic [FRAME_BITS-1:0]        frame,
  output logic [DATA_MSB-DATA_LSB:0]   value,
  output logic                         valid,
  output logic                         busy
);

  localparam int unsigned PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [7:0]    DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0]    QUIET_MAX  = 8'(CLK_DIV);
  localparam logic [PW-1:0] PER_LAST   = PW'(SAMPLE_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic [7:0]              div_q, div_d;
  logic [7:0]              quiet_q, quiet_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [PW-1:0]           per_q, per_d;
  logic                    pend_q, pend_d;
  logic                    en_q;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic                    valid_q, valid_d;
  logic                    sdo_s;
  logic                    period_hit, en_rise, div_done, quiet_ok, req;

  mfp_sync2 u_sync (
    .clock (clock),
    .reset (reset),
    .d     (sdo),
    .q     (sdo_s)
  );

  assign period_hit = enable && (per_q == PER_LAST);
  assign en_rise    = enable && !en_q;
  assign div_done   = (div_q == DIV_LAST);
  // Quiet counter holds the IDLE clocks already spent; the current one makes CLK_DIV.
  assign quiet_ok   = (quiet_q >= DIV_LAST);
  assign req        = pend_q || period_hit || en_rise || start;

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 8'd1;
    quiet_d = 8'd0;
    bit_d   = bit_q;
    shift_d = shift_q;
    frame_d = frame_q;
    valid_d = 1'b0;
    // Period/enable requests are remembered while busy; start is not.
    pend_d  = pend_q || period_hit || en_rise;
    if (!enable)
      per_d = '0;
    else if (per_q == PER_LAST)
      per_d = per_q;
    else
      per_d = per_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        div_d   = 8'd0;
        bit_d   = '0;
        quiet_d = (quiet_q == QUIET_MAX) ? quiet_q : quiet_q + 8'd1;
        pend_d  = req;
        if (quiet_ok && req) begin
          state_d = ST_SETUP;
          pend_d  = 1'b0;
          per_d   = '0;
        end
      end
      ST_SETUP: begin
        if (div_done) begin
          state_d = ST_LOW;
          div_d   = 8'd0;
        end
      end
      ST_LOW: begin
        if (div_done) begin
          state_d = ST_HIGH;
          div_d   = 8'd0;
        end
      end
      ST_HIGH: begin
        if (div_q == 8'd0)
          shift_d = {shift_q[FRAME_BITS-2:0], sdo_s};
        if (div_done) begin
          div_d = 8'd0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_HOLD;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = ST_LOW;
          end
        end
      end
      ST_HOLD: begin
        if (div_done) begin
          state_d = ST_IDLE;
          div_d   = 8'd0;
          frame_d = shift_q;
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= 8'd0;
      quiet_q <= 8'd0;
      bit_q   <= '0;
      per_q   <= '0;
      pend_q  <= 1'b0;
      en_q    <= 1'b0;
      shift_q <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      quiet_q <= quiet_d;
      bit_q   <= bit_d;
      per_q   <= per_d;
      pend_q  <= pend_d;
      en_q    <= enable;
      shift_q <= shift_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
    end
  end

  assign cs    = (state_q == ST_IDLE);
  assign sck   = (state_q != ST_LOW);
  assign busy  = (state_q != ST_IDLE);
  assign frame = frame_q;
  assign value = frame_q[DATA_MSB:DATA_LSB];
  assign valid = valid_q;

endmodule
